handshake_channel_arbiter: RTL and testbench
============================================

# handshake_channel_arbiter

Source-domain scheduler that shares one toggle-handshake clock-domain-crossing channel between several requesters (paddle inputs, score updates, game-state words) in the game-logic clock domain. Each cycle it picks one pending requester by round-robin, launches a single transfer tagged with the requester ID, and holds the channel until the synchronized acknowledge returns. A watchdog flags transfers whose acknowledge never arrives.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 16, payload bits per requester
- ID_WIDTH, 2, requester ID bits; must equal $clog2(NUM_REQ)
- TIMEOUT_CYCLES, 255, WAIT-state cycles before stall error; 0 disables watchdog

- i_clk  in  1  source-domain clock
- rst  in  1  synchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester pending flag
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k payload at [k*DATA_WIDTH +: DATA_WIDTH]
- o_req_ready  out  NUM_REQ  one-hot accept strobe, combinational
- o_ch_req  out  1  request toggle to channel
- o_ch_data  out  ID_WIDTH+DATA_WIDTH  {id, payload}, registered
- i_ch_ack  in  1  acknowledge toggle, already two-flop synchronized into i_clk
- o_busy  out  1  transfer outstanding
- o_grant_id  out  ID_WIDTH  ID of most recent launch
- o_stall_err  out  1  sticky watchdog error

## Operation
- Reset (rst=0 at a rising edge): state IDLE; o_ch_req=0, o_ch_data=0, o_grant_id=0, o_busy=0, o_stall_err=0, watchdog=0; round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, WAIT.
- IDLE: if any i_req_valid bit is set, winner k = first set bit searching from (last+1) mod NUM_REQ upward with wrap. In the same cycle o_req_ready[k]=1. At the edge: o_ch_data<={k,payload_k}, o_grant_id<=k, last<=k, o_ch_req<=~o_ch_req, watchdog<=0, go to WAIT. No valid bits set: stay in IDLE, outputs unchanged.
- o_req_ready is 0 in WAIT and 0 in IDLE when no valid bit is set. It is never multi-hot.
- Requester protocol: hold valid and data until ready is seen. Dropping valid before grant is legal; the requester is then simply not considered.
- WAIT: o_busy=1. Completion when i_ch_ack==o_ch_req; next state is IDLE. Otherwise stay in WAIT.
- Watchdog: increments every WAIT cycle without completion and saturates at TIMEOUT_CYCLES. Reaching TIMEOUT_CYCLES sets o_stall_err=1 until reset. The transfer is never aborted; WAIT continues until the ack arrives, because aborting would desynchronize the toggle pair.
- o_ch_data and o_ch_req change only on a launch edge. Payload is stable for the whole outstanding transfer.
- Fairness: a requester held valid continuously is granted within NUM_REQ launches.

## Timing
- Grant in IDLE cycle T (ready high during T). o_ch_req toggles and o_ch_data updates visibly at T+1. o_busy=1 from T+1.
- Ack matching in cycle W: IDLE at W+1, where a new grant can occur. The minimum launch spacing is 2 cycles plus the channel round trip.
- Simultaneous events:
  - A valid that rises during WAIT waits for IDLE.
  - If multiple valids are set in the same IDLE cycle, exactly one is granted, per round-robin.
- Pointer wrap: last=NUM_REQ-1 searches from 0.
- Reset mid-WAIT: next cycle IDLE, o_ch_req=0, outstanding transfer discarded. The channel's destination side shares rst, so its ack also returns to 0.
- Back-to-back payload words from one requester are separated by at least one launch of every other pending requester.

## Test plan
- Reset, then i_req_valid=4'b0001, data0=16'hA5A5, ack looped back after 4 cycles -> ready[0] pulses once; o_ch_req 0->1; o_ch_data={2'd0,16'hA5A5}; o_busy high for 4+ cycles; back to IDLE.
- All four valid continuously, ack echo after 3 cycles -> grant order 0,1,2,3,0,1; o_grant_id follows; o_ch_req toggles once per transfer.
- Valid 1 and 3 set with last=3 -> grant 1 then 3; then last=1 with valid 0 and 3 -> grant 3 before 0 (wrap check).
- TIMEOUT_CYCLES=8, ack withheld -> o_stall_err rises exactly 8 cycles after launch edge; o_busy stays 1; ack then toggles -> IDLE, o_stall_err stays 1 until reset.
- Assert rst=0 in WAIT with o_ch_req=1 -> next cycle o_ch_req=0, o_busy=0, o_stall_err=0; first subsequent grant goes to lowest-indexed valid requester.
- Valid pulsed for one cycle during WAIT then dropped -> no ready for it; no extra launch.

Source files
------------

// File: rtl/handshake_channel_arbiter_if.sv
// Requester-side and channel-side signals of the shared toggle-handshake CDC channel.
// The master modport is the arbiter. The slave modport is the requesters plus the channel.
interface handshake_channel_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_ch_req;
  logic [ID_WIDTH+DATA_WIDTH-1:0] o_ch_data;
  logic                          i_ch_ack;
  logic                          o_busy;
  logic [ID_WIDTH-1:0]           o_grant_id;
  logic                          o_stall_err;

  modport master (
    input  i_req_valid, i_req_data, i_ch_ack,
    output o_req_ready, o_ch_req, o_ch_data, o_busy, o_grant_id, o_stall_err
  );

  modport slave (
    output i_req_valid, i_req_data, i_ch_ack,
    input  o_req_ready, o_ch_req, o_ch_data, o_busy, o_grant_id, o_stall_err
  );
endinterface

// File: rtl/handshake_channel_arbiter.sv
// Round-robin scheduler that shares one toggle-handshake CDC channel among NUM_REQ requesters.
// It holds the channel until the toggle ack matches, and a sticky watchdog flags slow acks.
module handshake_channel_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic rst,
  handshake_channel_arbiter_if.master ch
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                         state;
  logic [ID_WIDTH-1:0]            last_q;
  logic [WD_W-1:0]                wd_q;
  logic [WD_W-1:0]                wd_nxt;
  logic                           ch_req_q;
  logic [ID_WIDTH+DATA_WIDTH-1:0] ch_data_q;
  logic [ID_WIDTH-1:0]            grant_q;
  logic                           busy_q;
  logic                           err_q;

  logic                           win_vld;
  logic [ID_WIDTH-1:0]            win_id;
  logic [ID_WIDTH-1:0]            cand;
  logic [DATA_WIDTH-1:0]          win_data;
  logic [NUM_REQ-1:0]             ready;

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(last_q) + i) % NUM_REQ);
      if (!win_vld && ch.i_req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_WIDTH'(k)) win_data = ch.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ready = '0;
    if (state == IDLE && win_vld) ready[win_id] = 1'b1;
  end

  assign wd_nxt = wd_q + WD_W'(1);

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_q    <= ID_WIDTH'(NUM_REQ - 1);
      wd_q      <= '0;
      ch_req_q  <= 1'b0;
      ch_data_q <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            ch_data_q <= {win_id, win_data};
            grant_q   <= win_id;
            last_q    <= win_id;
            ch_req_q  <= ~ch_req_q;
            wd_q      <= '0;
            busy_q    <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A late ack never aborts the transfer; dropping it would leave the toggles out of step.
          if (ch.i_ch_ack == ch_req_q) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && wd_q != WD_MAX) begin
            wd_q <= wd_nxt;
            if (wd_nxt == WD_MAX) err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch.o_req_ready = ready;
  assign ch.o_ch_req    = ch_req_q;
  assign ch.o_ch_data   = ch_data_q;
  assign ch.o_busy      = busy_q;
  assign ch.o_grant_id  = grant_q;
  assign ch.o_stall_err = err_q;

endmodule

// File: tb/tb_handshake_channel_arbiter.sv
// Scoreboard bench for handshake_channel_arbiter: a round-robin reference pushes each expected
// launch into a queue, and each observed ch_req toggle pops one entry and compares against it.
module tb_handshake_channel_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int TO = 8;

  logic i_clk = 1'b0;
  logic rst   = 1'b0;
  always #5 i_clk = ~i_clk;

  handshake_channel_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) ch ();

  handshake_channel_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk),
    .rst  (rst),
    .ch   (ch)
  );

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  valid = '0;
  logic [3:0]  keep  = '0;
  logic [15:0] dat [4];
  logic        ack   = 1'b0;
  int          ack_delay = 4;
  int          ack_cnt   = 0;
  bit          hold_ack  = 1'b0;

  bit          m_busy = 1'b0;
  bit          m_req  = 1'b0;
  bit          m_err  = 1'b0;
  int          m_last = NR - 1;
  int          m_wd   = 0;
  logic [17:0] sbq [$];
  int          glog [$];
  bit          prev_req = 1'b0;
  logic [3:0]  rdy_acc  = '0;

  logic        s_busy, s_stall, s_req;
  logic [17:0] s_data;
  logic [1:0]  s_gid;

  assign ch.i_req_valid = valid;
  assign ch.i_req_data  = {dat[3], dat[2], dat[1], dat[0]};
  assign ch.i_ch_ack    = ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= NR; i++) begin
      int j;
      j = (last + i) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock: sample and check at negedge, advance the reference at posedge, drive at +1.
  task automatic step();
    int          k;
    logic [3:0]  rdy_s;
    logic [3:0]  rdy_exp;
    logic [17:0] ev;
    bit          rst_e;
    @(negedge i_clk);
    rdy_s   = ch.o_req_ready;
    s_busy  = ch.o_busy;
    s_stall = ch.o_stall_err;
    s_req   = ch.o_ch_req;
    s_data  = ch.o_ch_data;
    s_gid   = ch.o_grant_id;
    if (rst) begin
      k = rr_pick(valid, m_last);
      rdy_exp = (m_busy || k < 0) ? 4'b0 : 4'(1 << k);
      chk("ready", 32'(rdy_s), 32'(rdy_exp));
      chk("busy", 32'(s_busy), 32'(m_busy));
      chk("stall_err", 32'(s_stall), 32'(m_err));
      chk("ch_req", 32'(s_req), 32'(m_req));
      if (s_req != prev_req) begin
        chk("sb_avail", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          ev = sbq.pop_front();
          chk("ch_data", 32'(s_data), 32'(ev));
          chk("grant_id", 32'(s_gid), 32'(ev[17:16]));
          glog.push_back(int'(s_gid));
        end
      end
    end
    prev_req = s_req;
    rdy_acc |= rdy_s;
    @(posedge i_clk);
    rst_e = rst;
    if (!rst) begin
      m_busy = 1'b0; m_req = 1'b0; m_err = 1'b0; m_last = NR - 1; m_wd = 0;
      sbq.delete();
    end else if (!m_busy) begin
      k = rr_pick(valid, m_last);
      if (k >= 0) begin
        sbq.push_back({2'(k), dat[k]});
        m_req = !m_req; m_last = k; m_busy = 1'b1; m_wd = 0;
      end
    end else if (ack == m_req) begin
      m_busy = 1'b0;
    end else if (m_wd < TO) begin
      m_wd++;
      if (m_wd == TO) m_err = 1'b1;
    end
    #1;
    if (rst_e) begin
      for (int q = 0; q < NR; q++) begin
        if (rdy_s[q]) begin
          if (keep[q]) dat[q] = dat[q] + 16'h1111;
          else valid[q] = 1'b0;
        end
      end
    end
    if (!rst_e) begin
      ack = 1'b0; ack_cnt = 0;
    end else if (!hold_ack && ch.o_ch_req != ack) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        ack = ch.o_ch_req; ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    step();
    step();
    chk({tag, "_rst_req"}, 32'(s_req), 32'd0);
    chk({tag, "_rst_busy"}, 32'(s_busy), 32'd0);
    chk({tag, "_rst_stall"}, 32'(s_stall), 32'd0);
    chk({tag, "_rst_gid"}, 32'(s_gid), 32'd0);
    chk({tag, "_rst_data"}, 32'(s_data), 32'd0);
    rst = 1'b1;
    glog.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      if (valid == 4'b0 && !s_busy && sbq.size() == 0) done = 1'b1;
    end
    chk({tag, "_idle_reached"}, 32'(done), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int n);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (glog.size() >= n) done = 1'b1;
    end
    chk({tag, "_grants_reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int exp_wrap  [5] = '{1, 3, 1, 3, 0};
    for (int q = 0; q < NR; q++) dat[q] = 16'(16'h1000 * (q + 1));

    // Single requester, ack looped back after 4 cycles
    do_reset("t1");
    ack_delay = 4;
    dat[0] = 16'hA5A5;
    valid  = 4'b0001;
    rdy_acc = '0;
    busy_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (s_busy) busy_cnt++;
    end
    chk("t1_launches", 32'(glog.size()), 32'd1);
    if (glog.size() != 0) chk("t1_gid", 32'(glog[0]), 32'd0);
    chk("t1_data", 32'(s_data), 32'h0A5A5);
    chk("t1_req", 32'(s_req), 32'd1);
    chk("t1_busy_4plus", 32'(busy_cnt >= 4), 32'd1);
    chk("t1_idle", 32'(s_busy), 32'd0);

    // All four requesters continuously valid, echo after 3 cycles
    do_reset("t2");
    ack_delay = 3;
    keep  = 4'b1111;
    valid = 4'b1111;
    wait_grants("t2", 6);
    valid = 4'b0;
    keep  = 4'b0;
    wait_idle("t2");
    for (int i = 0; i < 6; i++)
      if (i < glog.size()) chk($sformatf("t2_order%0d", i), 32'(glog[i]), 32'(exp_order[i]));

    // Round-robin wrap
    do_reset("t3");
    valid = 4'b1010;
    wait_idle("t3a");
    valid = 4'b0010;
    wait_idle("t3b");
    valid = 4'b1001;
    wait_idle("t3c");
    chk("t3_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk($sformatf("t3_order%0d", i), 32'(glog[i]), 32'(exp_wrap[i]));

    // Watchdog: ack withheld, error rises 8 cycles after the launch edge
    do_reset("t4");
    hold_ack = 1'b1;
    valid = 4'b0100;
    wait_grants("t4", 1);
    for (int c = 0; c < 7; c++) step();
    chk("t4_stall_early", 32'(s_stall), 32'd0);
    step();
    chk("t4_stall_rise", 32'(s_stall), 32'd1);
    chk("t4_busy_hold", 32'(s_busy), 32'd1);
    for (int c = 0; c < 5; c++) step();
    chk("t4_busy_still", 32'(s_busy), 32'd1);
    hold_ack = 1'b0;
    wait_idle("t4");
    chk("t4_stall_sticky", 32'(s_stall), 32'd1);

    // Reset in the middle of a WAIT
    do_reset("t5a");
    hold_ack = 1'b1;
    valid = 4'b0100;
    wait_grants("t5", 1);
    valid = valid | 4'b1010;
    step();
    step();
    chk("t5_in_wait_req", 32'(s_req), 32'd1);
    hold_ack = 1'b0;
    do_reset("t5b");
    wait_idle("t5");
    if (glog.size() != 0) chk("t5_first_grant", 32'(glog[0]), 32'd1);
    chk("t5_count", 32'(glog.size()), 32'd2);

    // One-cycle valid pulse during WAIT is ignored
    do_reset("t6");
    ack_delay = 6;
    valid = 4'b0001;
    wait_grants("t6", 1);
    rdy_acc = '0;
    valid[2] = 1'b1;
    step();
    valid[2] = 1'b0;
    wait_idle("t6");
    chk("t6_no_ready2", 32'(rdy_acc[2]), 32'd0);
    chk("t6_count", 32'(glog.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
